// File: rtl/tmc_spi_responder.sv
// tmc_spi_responder: TMC5130-style SPI register responder for 40-bit mode-3 datagrams.
// Define TMC_SPI_RESP_GSTAT_CLR_EN to clear register 0x01 on an SPI read (GSTAT clear-on-read).
module tmc_spi_responder #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [7:0]        status,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state, state_nxt;
    logic [2:0] sclk_s, csn_s;
    logic [1:0] mosi_s;
    logic [5:0] bit_cnt;
    logic [39:0] rx_shift, tx_shift;
    logic [31:0] rd_pipe;
    logic [31:0] regs [2**ADDR_W];
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [ADDR_W-1:0] addr;
    logic spi_we, clr;
    logic [31:0] commit_val;
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s <= '1;
            csn_s  <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            csn_s  <= {csn_s[1:0], csn};
            mosi_s <= {mosi_s[0], mosi};
        end
    end
    // csn sync resets low so a select held through reset never reads as a fresh fall
    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign csn_rise  = csn_s[1] & ~csn_s[2];
    assign csn_fall  = ~csn_s[1] & csn_s[2];
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE  ? (csn_fall ? SHIFT : IDLE) :
                    state == SHIFT ? (csn_rise ? (bit_cnt == 6'd40 ? COMMIT : IDLE) : SHIFT) :
                    IDLE;
    end
    always_comb begin
        miso    = state == SHIFT ? tx_shift[39] : 1'b1;
        miso_oe = state == SHIFT;
    end
    assign addr       = rx_shift[32 +: ADDR_W];
    assign spi_we     = state == COMMIT && rx_shift[39];
    assign commit_val = rx_shift[39] ? rx_shift[31:0] : regs[addr];
`ifdef TMC_SPI_RESP_GSTAT_CLR_EN
    assign clr = state == COMMIT && !rx_shift[39] && addr == ADDR_W'(1);
`else
    assign clr = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            rd_pipe    <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            host_rdata <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else begin
            wr_valid   <= spi_we;
            frame_err  <= state == SHIFT && csn_rise && bit_cnt != 6'd40;
            host_rdata <= regs[host_addr];
            if (state == IDLE && csn_fall) begin
                bit_cnt  <= '0;
                tx_shift <= {status, rd_pipe};
            end
            if (state == SHIFT && sclk_rise) begin
                rx_shift <= {rx_shift[38:0], mosi_s[1]};
                bit_cnt  <= bit_cnt + 6'(bit_cnt != 6'd41);
            end
            if (state == SHIFT && sclk_fall && bit_cnt != 6'd0) tx_shift <= {tx_shift[38:0], 1'b0};
            // later assignments win, so an SPI commit overrides a host write to the same address
            if (host_we) regs[host_addr] <= host_wdata;
            if (spi_we) begin
                regs[addr] <= rx_shift[31:0];
                wr_addr    <= addr;
                wr_data    <= rx_shift[31:0];
            end
            if (clr) regs[ADDR_W'(1)] <= '0;
            if (state == COMMIT) rd_pipe <= commit_val;
        end
    end
endmodule

// File: tb/tb_tmc_spi_responder.sv
// tb_tmc_spi_responder: scoreboard bench driving mode-3 SPI frames and host accesses.
module tb_tmc_spi_responder;
`ifdef TMC_SPI_RESP_GSTAT_CLR_EN
    localparam logic [31:0] GSTAT_AFTER = 32'h0;
`else
    localparam logic [31:0] GSTAT_AFTER = 32'h7;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1, sclk = 1'b1, csn = 1'b1, mosi = 1'b0, host_we = 1'b0;
    logic [7:0] status = 8'h00;
    logic [6:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic miso, miso_oe, wr_valid, frame_err;
    logic [31:0] host_rdata, wr_data;
    logic [6:0] wr_addr;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] model_regs [128];
    logic [31:0] model_pipe;
    logic [39:0] exp_rx [$];
    logic [38:0] exp_wr [$];
    logic [39:0] rx, want_rx;
    logic [38:0] want_wr;
    logic saw_wr, saw_err;
    logic [6:0] got_addr;
    logic [31:0] got_data, rv;

    always #5 clk = ~clk;

    tmc_spi_responder #(.ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .csn(csn), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .status(status),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model_regs[i] = '0;
        model_pipe = '0;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [31:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic host_read(input logic [6:0] a, output logic [31:0] v);
        host_addr = a;
        tick(2);
        v = host_rdata;
    endtask

    // Drives one frame; optionally lands a host write in the commit cycle.
    task automatic xfer(input logic [39:0] d, input int nbits, input bit collide,
                        input logic [6:0] h_addr, input logic [31:0] h_data);
        logic [6:0] a;
        a = d[38:32];
        exp_rx.push_back({status, model_pipe});
        if (nbits == 40 && d[39]) exp_wr.push_back({a, d[31:0]});
        rx = '0; saw_wr = 1'b0; saw_err = 1'b0; got_addr = '0; got_data = '0;
        csn = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0; mosi = d[39-i];
            tick(6);
            rx[39-i] = miso;
            sclk = 1'b1;
            tick(6);
        end
        csn = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (collide) begin
                host_addr = h_addr; host_wdata = h_data; host_we = (c == 3);
            end
            if (wr_valid) begin saw_wr = 1'b1; got_addr = wr_addr; got_data = wr_data; end
            if (frame_err) saw_err = 1'b1;
        end
        host_we = 1'b0;
        if (collide) model_regs[h_addr] = h_data;
        if (nbits == 40) begin
            if (d[39]) model_regs[a] = d[31:0];
            model_pipe = model_regs[a];
`ifdef TMC_SPI_RESP_GSTAT_CLR_EN
            if (!d[39] && a == 7'd1) model_regs[1] = '0;
`endif
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model_clear();
        tick(1);
        n_cmp++; if (miso !== 1'b1) begin n_bad++; $display("FAIL reset_miso got=%b want=1", miso); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_miso_oe got=%b want=0", miso_oe); end
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_valid got=%b want=0", wr_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        n_cmp++; if ({wr_addr, wr_data} !== 39'h0) begin n_bad++; $display("FAIL reset_wr got=%h/%h want=0/0", wr_addr, wr_data); end
        n_cmp++; if (host_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_host_rdata got=%h want=0", host_rdata); end
        tick(4);
    endtask

    task automatic test_write();
        status = 8'h11;
        xfer(40'h80_00000807, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL write_reply got=%h want=%h", rx, want_rx); end
        n_cmp++;
        if (!saw_wr || exp_wr.size() == 0) begin n_bad++; $display("FAIL write_pulse got=%b want=1", saw_wr); end
        else begin
            want_wr = exp_wr.pop_front();
            if ({got_addr, got_data} !== want_wr) begin n_bad++; $display("FAIL write_addr_data got=%h want=%h", {got_addr, got_data}, want_wr); end
        end
        n_cmp++; if (saw_err !== 1'b0) begin n_bad++; $display("FAIL write_frame_err got=%b want=0", saw_err); end
        host_read(7'd0, rv);
        n_cmp++; if (rv !== 32'h00000807) begin n_bad++; $display("FAIL write_host_read got=%h want=00000807", rv); end
    endtask

    task automatic test_read_reply();
        status = 8'hA5;
        xfer(40'h85_04030201, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL rr_first_reply got=%h want=%h", rx, want_rx); end
        if (exp_wr.size() != 0) want_wr = exp_wr.pop_front();
        n_cmp++; if ({saw_wr, got_addr, got_data} !== {1'b1, want_wr}) begin n_bad++; $display("FAIL rr_write got=%b/%h want=1/%h", saw_wr, {got_addr, got_data}, want_wr); end
        xfer(40'h05_00000000, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== 40'hA5_04030201) begin n_bad++; $display("FAIL rr_reply got=%h want=a504030201", rx); end
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL rr_reply_model got=%h want=%h", rx, want_rx); end
        n_cmp++; if (saw_wr !== 1'b0) begin n_bad++; $display("FAIL rr_read_no_write got=%b want=0", saw_wr); end
    endtask

    task automatic test_frame_err();
        xfer(40'h86_12345678, 39, 1'b0, 7'd0, 32'h0);
        void'(exp_rx.pop_front());
        n_cmp++; if (saw_err !== 1'b1) begin n_bad++; $display("FAIL ferr_pulse got=%b want=1", saw_err); end
        n_cmp++; if (saw_wr !== 1'b0) begin n_bad++; $display("FAIL ferr_no_write got=%b want=0", saw_wr); end
        host_read(7'd6, rv);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL ferr_reg6 got=%h want=0", rv); end
        xfer(40'h05_00000000, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== 40'hA5_04030201) begin n_bad++; $display("FAIL ferr_next_reply got=%h want=a504030201", rx); end
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL ferr_next_model got=%h want=%h", rx, want_rx); end
        n_cmp++; if (saw_err !== 1'b0) begin n_bad++; $display("FAIL ferr_good_frame got=%b want=0", saw_err); end
    endtask

    task automatic test_collision();
        xfer(40'h86_AAAA0001, 40, 1'b1, 7'd6, 32'h5555_0006);
        void'(exp_rx.pop_front());
        if (exp_wr.size() != 0) want_wr = exp_wr.pop_front();
        n_cmp++; if ({saw_wr, got_addr, got_data} !== {1'b1, want_wr}) begin n_bad++; $display("FAIL coll_write got=%b/%h want=1/%h", saw_wr, {got_addr, got_data}, want_wr); end
        host_read(7'd6, rv);
        n_cmp++; if (rv !== 32'hAAAA0001) begin n_bad++; $display("FAIL coll_same_addr got=%h want=aaaa0001", rv); end
        xfer(40'h86_BBBB0002, 40, 1'b1, 7'd7, 32'h7777_0007);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL coll_reply got=%h want=%h", rx, want_rx); end
        if (exp_wr.size() != 0) void'(exp_wr.pop_front());
        host_read(7'd6, rv);
        n_cmp++; if (rv !== 32'hBBBB0002) begin n_bad++; $display("FAIL coll_diff_spi got=%h want=bbbb0002", rv); end
        host_read(7'd7, rv);
        n_cmp++; if (rv !== 32'h77770007) begin n_bad++; $display("FAIL coll_diff_host got=%h want=77770007", rv); end
    endtask

    task automatic test_reset_midframe();
        logic [39:0] d;
        d = 40'h89_CAFEF00D;
        status = 8'h3C;
        csn = 1'b0;
        tick(6);
        for (int i = 0; i < 20; i++) begin
            sclk = 1'b0; mosi = d[39-i]; tick(6);
            sclk = 1'b1; tick(6);
        end
        n_cmp++; if (miso_oe !== 1'b1) begin n_bad++; $display("FAIL mid_oe_active got=%b want=1", miso_oe); end
        reset = 1'b1;
        tick(2);
        n_cmp++; if ({miso, miso_oe} !== 2'b10) begin n_bad++; $display("FAIL mid_reset_outputs got=%b want=10", {miso, miso_oe}); end
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b0; tick(6);
            sclk = 1'b1; tick(6);
        end
        n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL mid_low_csn_ignored got=%b want=0", miso_oe); end
        host_read(7'd6, rv);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL mid_regs_cleared got=%h want=0", rv); end
        csn = 1'b1;
        tick(8);
        xfer(40'h88_DEADBEEF, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== 40'h3C_00000000) begin n_bad++; $display("FAIL mid_next_reply got=%h want=3c00000000", rx); end
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL mid_next_model got=%h want=%h", rx, want_rx); end
        if (exp_wr.size() != 0) want_wr = exp_wr.pop_front();
        n_cmp++; if ({saw_wr, got_addr, got_data} !== {1'b1, 7'h08, 32'hDEADBEEF}) begin n_bad++; $display("FAIL mid_next_write got=%b/%h want=1/08deadbeef", saw_wr, {got_addr, got_data}); end
        host_read(7'd8, rv);
        n_cmp++; if (rv !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mid_reg8 got=%h want=deadbeef", rv); end
    endtask

    task automatic test_gstat();
        host_write(7'd1, 32'h7);
        xfer(40'h01_00000000, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL gstat_first_reply got=%h want=%h", rx, want_rx); end
        xfer(40'h01_00000000, 40, 1'b0, 7'd0, 32'h0);
        want_rx = exp_rx.pop_front();
        n_cmp++; if (rx !== {status, 32'h7}) begin n_bad++; $display("FAIL gstat_second_reply got=%h want=%h", rx, {status, 32'h7}); end
        n_cmp++; if (rx !== want_rx) begin n_bad++; $display("FAIL gstat_second_model got=%h want=%h", rx, want_rx); end
        host_read(7'd1, rv);
        n_cmp++; if (rv !== GSTAT_AFTER) begin n_bad++; $display("FAIL gstat_reg1_after got=%h want=%h", rv, GSTAT_AFTER); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_reply();
        test_frame_err();
        test_collision();
        test_reset_midframe();
        test_gstat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tmc_spi_responder.md
# tmc_spi_responder

Synthesizable SPI responder that emulates the TMC5130 register interface at the far end of the SPI link driven by `tmcspi`. It deserializes 40-bit mode-3 datagrams, commits writes to an internal register file, and returns the status byte and pipelined read data exactly as the driver chip does. It is used for FPGA loopback bring-up and as the device model in `tmcspi` benches.

## Interface
- `ADDR_W`, 7: register address width; register file depth is 2**ADDR_W × 32 bit.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from master, asynchronous, idle high.
- `csn`  in  1  SPI chip select, asynchronous, active low.
- `mosi`  in  1  SPI data from master, asynchronous.
- `miso`  out  1  SPI data to master.
- `miso_oe`  out  1  1 while a frame is selected.
- `status`  in  8  SPI_STATUS byte, captured at frame start.
- `host_addr`  in  ADDR_W  host-side register index.
- `host_we`  in  1  host write strobe.
- `host_wdata`  in  32  host write data.
- `host_rdata`  out  32  register[host_addr], one-cycle registered read.
- `wr_valid`  out  1  one-cycle pulse: SPI write committed.
- `wr_addr`  out  ADDR_W  address of the committed write.
- `wr_data`  out  32  data of the committed write.
- `frame_err`  out  1  one-cycle pulse: frame aborted with bit count ≠ 40.

## Operation
- `sclk`, `csn`, `mosi` pass through 2-FF synchronizers; edges detected from the synchronized copies.
- States: IDLE (csn high) → SHIFT (csn low) → COMMIT (one cycle) → IDLE.
- IDLE→SHIFT on synchronized csn fall: bit_cnt=0, tx_shift={status, rd_pipe}, miso_oe=1.
- SHIFT: on each sclk rise, rx_shift={rx_shift[38:0], mosi}, bit_cnt+1 (saturates at 41). On each sclk fall with bit_cnt≠0, tx_shift shifts left, filling with 0. `miso`=tx_shift[39].
- On csn rise: bit_cnt==40 → COMMIT; otherwise pulse `frame_err`, return to IDLE, no register or rd_pipe update.
- COMMIT: addr=rx_shift[38:32] truncated to ADDR_W (upper bits ignored); if rx_shift[39]=1, write rx_shift[31:0] to register[addr] and pulse `wr_valid`. Then rd_pipe ← register[addr] (value after any write). Reply data of frame N therefore reflects the address of frame N-1.
- Host write and SPI commit to the same address in the same cycle: SPI wins; host write dropped. Different addresses: both complete.
- Reset values: `miso`=1, `miso_oe`=0, `wr_valid`=0, `frame_err`=0, `wr_addr`=0, `wr_data`=0, `host_rdata`=0, rd_pipe=0, all registers 0, state IDLE.
- Reset mid-frame abandons the frame. The master must deassert and reassert csn before the next frame is accepted; a csn already low when reset releases is ignored.

## Timing
- Edge-detect latency: 3 clk from pin edge to action.
- Requirement: sclk high and low phases each ≥ 4 clk; csn setup/hold to sclk edges ≥ 4 clk.
- `miso` changes 3–4 clk after the sclk fall and is stable before the next sclk rise.
- COMMIT occurs 3 clk after the csn rise. `wr_valid` is asserted in the following cycle. rd_pipe is valid 1 clk after COMMIT.
- The next csn fall is permitted ≥ 6 clk after csn rise.
- `host_rdata`: 1 clk latency and reflects writes of the previous cycle.

## Configuration
- `TMC_SPI_RESP_GSTAT_CLR_EN` defined: an SPI read (rx_shift[39]=0) of address 0x01 latches the value into rd_pipe, then clears register[0x01] to 0 in the same COMMIT cycle. This emulates GSTAT clear-on-read.
- Not defined: address 0x01 behaves like any other register.

## Test plan
- Reset, then frame write 0x80 / 0x00000807 → `wr_valid` pulse with `wr_addr`=0x00, `wr_data`=0x00000807. Reading host_addr 0 returns 0x00000807.
- status=0xA5, write 0x85 / 0x04030201, then read frame 0x05 / 0 → second frame returns miso bytes A5 04 03 02 01.
- 39-clock frame with write 0x86 → `frame_err` pulse; register 6 stays 0; the next reply's data is unchanged.
- SPI commit and host_we to address 0x06 in the same cycle → register holds the SPI value. Repeat with the host at address 0x07 → both values are stored.
- Assert `reset` after 20 sclk bits → outputs return to reset values. The next full frame after a csn toggle is accepted normally.
- With the macro defined, preload register 1=0x00000007 via host, then send read 0x01 twice → the second reply data is 7. Register 1 reads 0 afterwards. Without the macro, register 1 stays 7.
